pixel_input_capture: RTL and testbench
======================================

Name: pixel_input_capture

Overview:
- Front stage inside edge_detection_top, directly after the input pads.
- Oversamples the external video interface (I_PCLK, I_VSYNC, I_HSYNC, I_DE, I_PIX_DATA) in the I_CORE_CLK domain and detects pixel-clock rising edges.
- Converts each active RGB888 pixel to 8-bit luma and tags it with x/y coordinates and frame/line markers.
- Feeds the line-buffer/Sobel stage.

Parameters:
- SYNC_STAGES, 2, flop depth of input synchronizers (min 2).
- X_W, 11, width of column counter.
- Y_W, 11, width of row counter.
- MAX_W, 1280, max active pixels per line before overflow.

Ports:
- I_CORE_CLK  in  1  core clock; all logic on its rising edge.
- I_RST  in  1  reset; asynchronous, active-high.
- I_PIX_DATA  in  24  RGB888 pixel: R=[23:16], G=[15:8], B=[7:0].
- I_VSYNC  in  1  frame sync, active-high.
- I_HSYNC  in  1  line sync, active-high.
- I_DE  in  1  data enable, active-high.
- I_PCLK  in  1  pixel clock, treated as data.
- O_PIX_VALID  out  1  one-cycle pulse per captured active pixel.
- O_PIX_LUMA  out  8  luma of captured pixel.
- O_PIX_X  out  X_W  column of pixel, 0-based.
- O_PIX_Y  out  Y_W  row of pixel, 0-based.
- O_SOF  out  1  high with O_PIX_VALID on pixel (0,0) of a frame.
- O_EOL  out  1  one-cycle pulse when an active line ends.
- O_VSYNC_S  out  1  last sampled VSYNC.
- O_HSYNC_S  out  1  last sampled HSYNC.
- O_DE_S  out  1  last sampled DE.
- O_OVERFLOW  out  1  line exceeded MAX_W; sticky until next frame start.

Behaviour:
- Reset: all outputs 0, counters 0, synchronizers 0, FSM in S_WAIT_VS. Reset mid-frame aborts the frame.
- Synchronization:
  - All 28 inputs pass through SYNC_STAGES flops, so the delay is identical for all of them.
  - Sample event = synced PCLK is 1 while its one-cycle-delayed copy is 0.
  - Required ratio: I_CORE_CLK >= 4x PCLK frequency.
- On each sample event, register the sampled VSYNC/HSYNC/DE into O_*_S and keep the previous sampled DE/VSYNC for edge detection.
- Luma: Y = (77*R + 150*G + 29*B + 128) >> 8.
  - 16-bit unsigned intermediate; result is always <= 255, no saturation logic.
  - White FFFFFF -> 255; black -> 0.
- FSM S_WAIT_VS: ignore DE. A sampled VSYNC rising edge goes to S_FRAME with x=0, y=0, first_pix=1, O_OVERFLOW=0.
- FSM S_FRAME:
  - Sampled DE=1: O_PIX_VALID=1 next cycle with O_PIX_LUMA, O_PIX_X=x, O_PIX_Y=y, O_SOF=first_pix. Then x++ and first_pix=0.
  - Sampled DE falling edge: O_EOL=1 next cycle, x=0, y++ (y wraps at 2^Y_W).
  - Sampled VSYNC rising edge: reset x, y, first_pix and O_OVERFLOW; stay in S_FRAME.
  - Same-sample VSYNC rise and DE=1: apply the VSYNC restart first, then emit the pixel as (0,0) with O_SOF=1.
  - DE=1 when x == MAX_W: drop the pixel, O_OVERFLOW=1, go to S_WAIT_VS.
- Latency: O_PIX_VALID asserts SYNC_STAGES+2 core cycles after I_PCLK rises at the port. Fixed and identical for O_EOL.
- All outputs are registered. O_PIX_VALID, O_SOF and O_EOL are single-cycle pulses. Data outputs hold their value between pulses.
- HSYNC is not used for counting; it is passed through only.

Test Plan:
- Reset, then 3 frames of 4x3 active pixels, PCLK = core/4 -> 12 O_PIX_VALID per frame, X 0..3, Y 0..2, O_SOF only at (0,0), 3 O_EOL per frame, latency 4 core cycles.
- Luma values, one pixel each: FFFFFF -> 255; 000000 -> 0; FF0000 -> 77; 00FF00 -> 149; 0000FF -> 29.
- DE pixels before the first VSYNC after reset -> no O_PIX_VALID. The first VSYNC rise starts counting at (0,0).
- Line of MAX_W+1 DE pixels (MAX_W=8 override) -> 8 valid pulses, then O_OVERFLOW=1 and no further output until VSYNC. O_OVERFLOW clears on that VSYNC.
- VSYNC rise in the same PCLK sample as DE=1 mid-frame -> pixel emitted with X=0, Y=0, O_SOF=1.
- Assert I_RST mid-line -> all outputs 0 immediately (asynchronous). After release, no output until the next VSYNC rise.

Source files
------------

// File: rtl/pixel_input_capture.sv
// Video input front end: oversamples the external pixel interface in the core clock
// domain, converts active RGB888 pixels to luma and tags them with coordinates.
module pixel_input_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int X_W         = 11,
    parameter int Y_W         = 11,
    parameter int MAX_W       = 1280
) (
    input  logic           I_CORE_CLK,
    input  logic           I_RST,
    input  logic [23:0]    I_PIX_DATA,
    input  logic           I_VSYNC,
    input  logic           I_HSYNC,
    input  logic           I_DE,
    input  logic           I_PCLK,
    output logic           O_PIX_VALID,
    output logic [7:0]     O_PIX_LUMA,
    output logic [X_W-1:0] O_PIX_X,
    output logic [Y_W-1:0] O_PIX_Y,
    output logic           O_SOF,
    output logic           O_EOL,
    output logic           O_VSYNC_S,
    output logic           O_HSYNC_S,
    output logic           O_DE_S,
    output logic           O_OVERFLOW
);

    localparam int IN_W = 28;
    localparam logic [X_W-1:0] LP_MAX_X = X_W'(MAX_W);

    typedef enum logic {
        S_WAIT_VS = 1'b0,
        S_FRAME   = 1'b1
    } state_t;

    // Rounded BT.601-style luma; the weights sum to 256 so the result never exceeds 255.
    function automatic logic [7:0] f_luma(input logic [23:0] px);
        logic [15:0] acc;
        acc = 16'd77  * 16'(px[23:16])
            + 16'd150 * 16'(px[15:8])
            + 16'd29  * 16'(px[7:0])
            + 16'd128;
        return 8'(acc >> 8);
    endfunction

    logic [IN_W-1:0] r_sync [SYNC_STAGES];
    logic [IN_W-1:0] w_sync;
    logic            w_pclk_s;
    logic            r_pclk_d;
    logic            w_event;

    // Synchronizer stage: every input shares the same flop chain so they stay aligned
    always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
        if (I_RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_pclk_d <= 1'b0;
        end else begin
            r_sync[0] <= {I_PCLK, I_VSYNC, I_HSYNC, I_DE, I_PIX_DATA};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_pclk_d <= w_pclk_s;
        end
    end

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_pclk_s = w_sync[27];
    assign w_event  = w_pclk_s & ~r_pclk_d;

    logic        r_vld_p0;
    logic [23:0] r_data_p0;
    logic        r_vs_p0;
    logic        r_hs_p0;
    logic        r_de_p0;
    logic        r_vs_prev;
    logic        r_de_prev;

    // Stage p0: capture one sample per pixel-clock rising edge
    always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_vld_p0  <= 1'b0;
            r_data_p0 <= '0;
            r_vs_p0   <= 1'b0;
            r_hs_p0   <= 1'b0;
            r_de_p0   <= 1'b0;
            r_vs_prev <= 1'b0;
            r_de_prev <= 1'b0;
        end else begin
            r_vld_p0 <= w_event;
            if (w_event) begin
                r_data_p0 <= w_sync[23:0];
                r_de_p0   <= w_sync[24];
                r_hs_p0   <= w_sync[25];
                r_vs_p0   <= w_sync[26];
                r_vs_prev <= r_vs_p0;
                r_de_prev <= r_de_p0;
            end
        end
    end

    logic w_vs_rise;
    logic w_de_fall;

    assign w_vs_rise = r_vs_p0 & ~r_vs_prev;
    assign w_de_fall = ~r_de_p0 & r_de_prev;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [X_W-1:0] r_x;
    logic [X_W-1:0] w_x_nxt;
    logic [Y_W-1:0] r_y;
    logic [Y_W-1:0] w_y_nxt;
    logic           r_first;
    logic           w_first_nxt;
    logic           r_ovf;
    logic           w_ovf_nxt;
    logic           w_emit;
    logic           w_sof;
    logic           w_eol;
    logic [X_W-1:0] w_px;
    logic [Y_W-1:0] w_py;

    // A VSYNC restart is applied before the pixel of the same sample is tagged
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_first_nxt = r_first;
        w_ovf_nxt   = r_ovf;
        w_emit      = 1'b0;
        w_sof       = 1'b0;
        w_eol       = 1'b0;
        w_px        = r_x;
        w_py        = r_y;
        if (r_vld_p0) begin
            case (r_state)
                S_WAIT_VS: begin
                    if (w_vs_rise) begin
                        w_state_nxt = S_FRAME;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_first_nxt = 1'b1;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                S_FRAME: begin
                    if (w_vs_rise) begin
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_first_nxt = 1'b1;
                        w_ovf_nxt   = 1'b0;
                    end
                    if (r_de_p0) begin
                        if (w_x_nxt == LP_MAX_X) begin
                            w_ovf_nxt   = 1'b1;
                            w_state_nxt = S_WAIT_VS;
                        end else begin
                            w_emit      = 1'b1;
                            w_sof       = w_first_nxt;
                            w_px        = w_x_nxt;
                            w_py        = w_y_nxt;
                            w_x_nxt     = w_x_nxt + X_W'(1);
                            w_first_nxt = 1'b0;
                        end
                    end else if (w_de_fall) begin
                        w_eol   = 1'b1;
                        w_x_nxt = '0;
                        if (!w_vs_rise) begin
                            w_y_nxt = w_y_nxt + Y_W'(1);
                        end
                    end
                end
                default: w_state_nxt = S_WAIT_VS;
            endcase
        end
    end

    logic           r_pix_vld_p1;
    logic           r_sof_p1;
    logic           r_eol_p1;
    logic [7:0]     r_luma_p1;
    logic [X_W-1:0] r_px_p1;
    logic [Y_W-1:0] r_py_p1;

    // Stage p1: frame state and registered outputs; data outputs hold between pulses
    always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_state      <= S_WAIT_VS;
            r_x          <= '0;
            r_y          <= '0;
            r_first      <= 1'b0;
            r_ovf        <= 1'b0;
            r_pix_vld_p1 <= 1'b0;
            r_sof_p1     <= 1'b0;
            r_eol_p1     <= 1'b0;
            r_luma_p1    <= '0;
            r_px_p1      <= '0;
            r_py_p1      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_first      <= w_first_nxt;
            r_ovf        <= w_ovf_nxt;
            r_pix_vld_p1 <= w_emit;
            r_sof_p1     <= w_sof;
            r_eol_p1     <= w_eol;
            if (w_emit) begin
                r_luma_p1 <= f_luma(r_data_p0);
                r_px_p1   <= w_px;
                r_py_p1   <= w_py;
            end
        end
    end

    assign O_PIX_VALID = r_pix_vld_p1;
    assign O_PIX_LUMA  = r_luma_p1;
    assign O_PIX_X     = r_px_p1;
    assign O_PIX_Y     = r_py_p1;
    assign O_SOF       = r_sof_p1;
    assign O_EOL       = r_eol_p1;
    assign O_VSYNC_S   = r_vs_p0;
    assign O_HSYNC_S   = r_hs_p0;
    assign O_DE_S      = r_de_p0;
    assign O_OVERFLOW  = r_ovf;

endmodule

// File: tb/tb_pixel_input_capture.sv
// Bench for pixel_input_capture: randomized video frames against a frame-level
// reference model, with a queue-based scoreboard checking every output pulse.
module tb_pixel_input_capture;

    localparam int MAXW = 8;
    localparam int LAT  = 4;

    logic        I_CORE_CLK = 1'b0;
    logic        I_RST      = 1'b1;
    logic [23:0] I_PIX_DATA = '0;
    logic        I_VSYNC    = 1'b0;
    logic        I_HSYNC    = 1'b0;
    logic        I_DE       = 1'b0;
    logic        I_PCLK     = 1'b0;
    logic        O_PIX_VALID;
    logic [7:0]  O_PIX_LUMA;
    logic [10:0] O_PIX_X;
    logic [10:0] O_PIX_Y;
    logic        O_SOF;
    logic        O_EOL;
    logic        O_VSYNC_S;
    logic        O_HSYNC_S;
    logic        O_DE_S;
    logic        O_OVERFLOW;

    pixel_input_capture #(.SYNC_STAGES(2), .X_W(11), .Y_W(11), .MAX_W(MAXW)) dut (
        .I_CORE_CLK (I_CORE_CLK),
        .I_RST      (I_RST),
        .I_PIX_DATA (I_PIX_DATA),
        .I_VSYNC    (I_VSYNC),
        .I_HSYNC    (I_HSYNC),
        .I_DE       (I_DE),
        .I_PCLK     (I_PCLK),
        .O_PIX_VALID(O_PIX_VALID),
        .O_PIX_LUMA (O_PIX_LUMA),
        .O_PIX_X    (O_PIX_X),
        .O_PIX_Y    (O_PIX_Y),
        .O_SOF      (O_SOF),
        .O_EOL      (O_EOL),
        .O_VSYNC_S  (O_VSYNC_S),
        .O_HSYNC_S  (O_HSYNC_S),
        .O_DE_S     (O_DE_S),
        .O_OVERFLOW (O_OVERFLOW)
    );

    always #5 I_CORE_CLK = ~I_CORE_CLK;

    int cyc = 0;
    always @(posedge I_CORE_CLK) cyc <= cyc + 1;

    typedef struct {
        bit eol;
        int luma;
        int x;
        int y;
        bit sof;
        int cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: frame-level view of the video stream
    bit m_in_frame, m_prev_vs, m_prev_de, m_ovf, m_first, m_hs;
    int m_x, m_y;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_prev_vs = 0; m_prev_de = 0; m_ovf = 0;
        m_first = 0; m_hs = 0; m_x = 0; m_y = 0;
        q.delete();
    endtask

    function automatic int luma_of(input logic [23:0] d);
        int r, g, b;
        r = int'(d[23:16]); g = int'(d[15:8]); b = int'(d[7:0]);
        return (77 * r + 150 * g + 29 * b + 128) / 256;
    endfunction

    task automatic model_sample(input bit de, input bit vs, input logic [23:0] d);
        bit vs_rise, de_fall;
        exp_t e;
        vs_rise = vs && !m_prev_vs;
        de_fall = !de && m_prev_de;
        if (vs_rise) begin
            m_in_frame = 1; m_x = 0; m_y = 0; m_first = 1; m_ovf = 0;
        end
        if (m_in_frame && de) begin
            if (m_x == MAXW) begin
                m_ovf = 1;
                m_in_frame = 0;
            end else begin
                e.eol = 0; e.luma = luma_of(d); e.x = m_x; e.y = m_y;
                e.sof = m_first; e.cyc = cyc + LAT;
                q.push_back(e);
                m_x++;
                m_first = 0;
            end
        end else if (m_in_frame && de_fall) begin
            e.eol = 1; e.luma = 0; e.x = 0; e.y = 0; e.sof = 0; e.cyc = cyc + LAT;
            q.push_back(e);
            m_x = 0;
            if (!vs_rise) m_y = (m_y + 1) % 2048;
        end
        m_prev_vs = vs;
        m_prev_de = de;
    endtask

    // One pixel-clock period = 4 core cycles; entered and left at posedge+1
    task automatic samp(input bit de, input bit vs, input bit hs, input logic [23:0] d);
        I_DE = de; I_VSYNC = vs; I_HSYNC = hs; I_PIX_DATA = d; I_PCLK = 1'b1;
        m_hs = hs;
        model_sample(de, vs, d);
        repeat (2) @(posedge I_CORE_CLK);
        #1 I_PCLK = 1'b0;
        repeat (2) @(posedge I_CORE_CLK);
        #1;
    endtask

    task automatic frame(input int w, input int h);
        samp(0, 1, 0, 24'h0);
        samp(0, 0, 0, 24'h0);
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) samp(1, 0, 0, 24'($urandom));
            samp(0, 0, 1, 24'h0);
            samp(0, 0, 1'($urandom), 24'h0);
        end
    endtask

    task automatic settle(input string nm);
        repeat (6) @(posedge I_CORE_CLK);
        #1;
        chk({nm, "_overflow"}, 32'(O_OVERFLOW), 32'(m_ovf));
        chk({nm, "_de_s"}, 32'(O_DE_S), 32'(m_prev_de));
        chk({nm, "_vsync_s"}, 32'(O_VSYNC_S), 32'(m_prev_vs));
        chk({nm, "_hsync_s"}, 32'(O_HSYNC_S), 32'(m_hs));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, 32'(O_PIX_VALID), 0);
        chk({nm, "_luma"}, 32'(O_PIX_LUMA), 0);
        chk({nm, "_x"}, 32'(O_PIX_X), 0);
        chk({nm, "_y"}, 32'(O_PIX_Y), 0);
        chk({nm, "_sof"}, 32'(O_SOF), 0);
        chk({nm, "_eol"}, 32'(O_EOL), 0);
        chk({nm, "_syncs"}, 32'({O_VSYNC_S, O_HSYNC_S, O_DE_S}), 0);
        chk({nm, "_overflow"}, 32'(O_OVERFLOW), 0);
    endtask

    // Monitor: every output pulse is matched against the oldest expected event
    initial begin
        exp_t e;
        forever begin
            @(negedge I_CORE_CLK);
            if (O_PIX_VALID || O_EOL) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output actual valid=%0b eol=%0b x=%0d y=%0d required none",
                             O_PIX_VALID, O_EOL, O_PIX_X, O_PIX_Y);
                end else begin
                    e = q.pop_front();
                    if (e.eol) begin
                        if (!(O_EOL === 1'b1 && O_PIX_VALID === 1'b0 && cyc == e.cyc)) begin
                            errors++;
                            $display("FAIL eol_pulse actual eol=%0b valid=%0b cyc=%0d required eol=1 valid=0 cyc=%0d",
                                     O_EOL, O_PIX_VALID, cyc, e.cyc);
                        end
                    end else begin
                        if (!(O_PIX_VALID === 1'b1 && O_EOL === 1'b0 && int'(O_PIX_LUMA) == e.luma &&
                              int'(O_PIX_X) == e.x && int'(O_PIX_Y) == e.y && O_SOF === e.sof &&
                              cyc == e.cyc)) begin
                            errors++;
                            $display("FAIL pixel actual v=%0b eol=%0b luma=%0d x=%0d y=%0d sof=%0b cyc=%0d required v=1 eol=0 luma=%0d x=%0d y=%0d sof=%0b cyc=%0d",
                                     O_PIX_VALID, O_EOL, O_PIX_LUMA, O_PIX_X, O_PIX_Y, O_SOF, cyc,
                                     e.luma, e.x, e.y, e.sof, e.cyc);
                        end
                    end
                end
            end else if (O_SOF) begin
                checks++;
                errors++;
                $display("FAIL sof_without_valid actual sof=1 required sof=0");
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge I_CORE_CLK);
        #1;
        chk_all_zero("reset");
        I_RST = 1'b0;
        @(posedge I_CORE_CLK);
        #1;

        // DE activity before any VSYNC must be ignored
        for (int i = 0; i < 3; i++) samp(1, 0, 0, 24'($urandom));
        samp(0, 0, 0, 24'h0);
        settle("pre_vsync");

        for (int f = 0; f < 3; f++) frame(4, 3);
        settle("frames4x3");

        // Directed luma corners on a single line
        samp(0, 1, 0, 24'h0);
        samp(0, 0, 0, 24'h0);
        samp(1, 0, 0, 24'hFFFFFF);
        samp(1, 0, 0, 24'h000000);
        samp(1, 0, 0, 24'hFF0000);
        samp(1, 0, 0, 24'h00FF00);
        samp(1, 0, 0, 24'h0000FF);
        samp(0, 0, 0, 24'h0);
        settle("luma");

        // Line longer than MAX_W: overflow, then silence until the next VSYNC
        frame(MAXW + 1, 1);
        settle("overflow_set");
        chk("overflow_model_set", 32'(O_OVERFLOW), 1);
        for (int i = 0; i < 3; i++) samp(1, 0, 0, 24'($urandom));
        samp(0, 0, 0, 24'h0);
        settle("overflow_hold");
        frame(2, 1);
        settle("overflow_clear");

        // VSYNC rising together with an active pixel restarts at (0,0)
        frame(3, 1);
        samp(1, 0, 0, 24'($urandom));
        samp(1, 0, 0, 24'($urandom));
        samp(1, 1, 0, 24'($urandom));
        samp(1, 0, 0, 24'($urandom));
        samp(0, 0, 0, 24'h0);
        samp(0, 0, 0, 24'h0);
        settle("vs_with_de");

        for (int f = 0; f < 6; f++) frame($urandom_range(1, 10), $urandom_range(1, 3));
        settle("random");

        // Asynchronous reset in the middle of a line
        samp(0, 1, 0, 24'h0);
        samp(0, 0, 0, 24'h0);
        samp(1, 0, 0, 24'hFFFFFF);
        samp(1, 0, 0, 24'hFFFFFF);
        I_DE = 1'b1; I_PIX_DATA = 24'hFFFFFF; I_PCLK = 1'b1;
        model_sample(1, 0, 24'hFFFFFF);
        repeat (2) @(posedge I_CORE_CLK);
        #1 I_PCLK = 1'b0;
        @(posedge I_CORE_CLK);
        #2 I_RST = 1'b1;
        #1;
        chk_all_zero("midline_reset");
        model_reset();
        @(posedge I_CORE_CLK);
        #1 I_RST = 1'b0;
        for (int i = 0; i < 3; i++) samp(1, 0, 0, 24'($urandom));
        samp(0, 0, 0, 24'h0);
        settle("post_reset_idle");
        frame(3, 2);
        settle("post_reset_frame");

        repeat (10) @(posedge I_CORE_CLK);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
